// File: rtl/dmem_responder.sv
// dmem_responder: word-array data memory behind a request/response handshake.
// One transaction is outstanding at a time. Each transaction passes through
// IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP. The memory is accessed on the
// edge that enters RESP. Every output is driven straight from a flop.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Request captured at acceptance; the requester may change its inputs afterwards
  logic             we_p0;
  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       be_p0;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             exec_ok;
  logic             x_we;
  logic [31:0]      x_addr;
  logic [31:0]      x_wdata;
  logic [3:0]       x_be;
  logic             x_err;
  logic [IDX_W-1:0] x_idx;
  logic [31:0]      x_rdata;

  // Address outside the window or not word-aligned. The comparison is done
  // at 33 bits so that a window ending at 4 GiB does not wrap around.
  function automatic logic addr_err(input logic [31:0] a);
    logic [32:0] a_x;
    logic [32:0] lo;
    logic [32:0] hi;
    a_x = {1'b0, a};
    lo  = {1'b0, BASE_ADDR};
    hi  = lo + (33'(DEPTH_WORDS) << 2);
    return (a[1:0] != 2'b00) || (a_x < lo) || (a_x >= hi);
  endfunction

  // Word index relative to BASE_ADDR. Only meaningful when addr_err is 0.
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == '0));
  assign exec_ok    = rst_n && enter_resp;

  // With zero wait states, execution happens on the acceptance edge itself.
  // In that case the live request is used, because the latch is not yet loaded.
  assign x_we    = (state == IDLE) ? req_we    : we_p0;
  assign x_addr  = (state == IDLE) ? req_addr  : addr_p0;
  assign x_wdata = (state == IDLE) ? req_wdata : wdata_p0;
  assign x_be    = (state == IDLE) ? req_be    : be_p0;
  assign x_err   = addr_err(x_addr);
  assign x_idx   = word_idx(x_addr);
  assign x_rdata = (!x_we && !x_err) ? mem[x_idx] : 32'h0;

  // Capture the request fields on the acceptance edge
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      be_p0    <= req_be;
    end
  end

  // Store path: write the enabled bytes of a valid store on the execute edge
  always_ff @(posedge clk) begin
    if (exec_ok && x_we && !x_err) begin
      for (int b = 0; b < 4; b++) begin
        if (x_be[b]) begin
          mem[x_idx][8*b +: 8] <= x_wdata[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= x_err;
        rsp_rdata <= x_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. It drives a WAIT_CYCLES=2 instance (a_*) with
// a directed vector table, hand-written reset and backpressure sequences, and
// random traffic checked against a word-array reference model. It also drives
// a WAIT_CYCLES=0 instance (b_*) through a back-to-back sequence.
module tb_dmem_responder;

  localparam int  WAIT_A = 2;
  localparam int  DEPTH  = 256;
  localparam longint BASE = 64'h0;

  logic        clk;
  int          cyc;
  int          checks;
  int          errors;
  int          last_acc;

  logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  bit [31:0] mem_m [int];

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    bit [31:0] exp_rd;
    bit        exp_er;
  } vec_t;

  vec_t tbl [13];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: the memory as a sparse word array, evaluated from the address rules
  function automatic void ref_exec(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                                   input bit [3:0] be, output bit [31:0] rd, output bit er);
    longint a;
    int     idx;
    bit [31:0] w;
    a  = longint'(addr);
    er = (addr % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH);
    rd = 32'h0;
    if (!er) begin
      idx = int'((a - BASE) / 4);
      if (we) begin
        w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mem_m[idx] = w;
      end else begin
        rd = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      end
    end
  endfunction

  // One complete transaction on instance A, with optional response backpressure
  task automatic txn_a(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                       input bit [3:0] be, input int hold,
                       input bit [31:0] exp_rd, input bit exp_er);
    int n;
    int lat;
    int acc;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    a_req_valid = 1'b1;
    a_rsp_ready = 1'b0;
    n = 0;
    while (a_req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (a_req_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      a_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    a_req_valid = 1'b0;
    a_req_we    = ~we;
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
    a_req_be    = 4'($urandom_range(0, 15));
    if (last_acc >= 0) chk("spacing_ok", 32'((acc - last_acc) >= WAIT_A + 2), 32'd1);
    last_acc = acc;
    lat = 1;
    while (a_rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(WAIT_A + 1));
    chk("busy_ready", 32'(a_req_ready), 32'd0);
    chk("rdata", a_rsp_rdata, exp_rd);
    chk("err", 32'(a_rsp_err), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_rdata", a_rsp_rdata, exp_rd);
      chk("bp_err", 32'(a_rsp_err), 32'(exp_er));
      chk("bp_ready", 32'(a_req_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    chk("done_valid", 32'(a_rsp_valid), 32'd0);
    chk("done_ready", 32'(a_req_ready), 32'd1);
    chk("done_rdata", a_rsp_rdata, 32'd0);
    chk("done_err", 32'(a_rsp_err), 32'd0);
  endtask

  initial begin
    bit [31:0] erd;
    bit        eer;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [3:0]  be;
    bit        we;
    int        k;
    int        sel;

    checks = 0;
    errors = 0;
    last_acc = -1;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h20,  32'h01020304, 4'h0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
    tbl[7]  = '{1'b1, 32'h3FC, 32'h5A5A1234, 4'hF, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h6,   32'h0,        4'hF, 32'h0,        1'b1};
    tbl[9]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h5A5A1234, 1'b0};
    tbl[11] = '{1'b1, 32'h30,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 32'h30,  32'h0,        4'hF, 32'hCAFEF00D, 1'b0};

    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0;
    a_req_wdata = 32'h0; a_req_be = 4'h0; a_rsp_ready = 1'b0;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0;
    b_req_wdata = 32'h0; b_req_be = 4'h0; b_rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_a_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_a_rsp_err", 32'(a_rsp_err), 32'd0);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Directed vectors
    foreach (tbl[i]) begin
      ref_exec(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, erd, eer);
      txn_a(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0, tbl[i].exp_rd, tbl[i].exp_er);
    end

    // Backpressure: response held five cycles
    txn_a(1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT drops the in-flight store
    a_req_we = 1'b1; a_req_addr = 32'h30; a_req_wdata = 32'h12345678; a_req_be = 4'hF;
    a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    chk("mid_wait_ready", 32'(a_req_ready), 32'd0);
    chk("mid_wait_valid", 32'(a_rsp_valid), 32'd0);
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    chk("mid_rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("mid_rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("mid_rst_rsp_err", 32'(a_rsp_err), 32'd0);
    last_acc = -1;
    txn_a(1'b0, 32'h30, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1'b0);

    // Random traffic against the reference model
    for (int j = 0; j < 16; j++) begin
      addr = 32'h100 + 32'(4 * j);
      wd   = $urandom;
      ref_exec(1'b1, addr, wd, 4'hF, erd, eer);
      txn_a(1'b1, addr, wd, 4'hF, 0, erd, eer);
    end
    for (int t = 0; t < 60; t++) begin
      k    = $urandom_range(0, 15);
      sel  = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      addr = 32'h100 + 32'(4 * k);
      if (sel == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (sel == 1) addr = (t % 2 == 1) ? 32'hFFFF_FFFC : 32'h400 + 32'(4 * k);
      ref_exec(we, addr, wd, be, erd, eer);
      txn_a(we, addr, wd, be, $urandom_range(0, 3), erd, eer);
    end

    // Zero-wait instance: response one cycle after acceptance, accept every 2 cycles
    b_req_we = 1'b1; b_req_addr = 32'h40; b_req_wdata = 32'h0BADCAFE; b_req_be = 4'hF;
    b_req_valid = 1'b1; b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("b_st_valid", 32'(b_rsp_valid), 32'd1);
    chk("b_st_ready", 32'(b_req_ready), 32'd0);
    chk("b_st_rdata", b_rsp_rdata, 32'd0);
    chk("b_st_err", 32'(b_rsp_err), 32'd0);
    b_req_we = 1'b0;
    @(posedge clk); #1;
    chk("b_idle_valid", 32'(b_rsp_valid), 32'd0);
    chk("b_idle_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("b_ld_valid", 32'(b_rsp_valid), 32'd1);
    chk("b_ld_rdata", b_rsp_rdata, 32'h0BADCAFE);
    chk("b_ld_err", 32'(b_rsp_err), 32'd0);
    b_req_addr = 32'h42;
    @(posedge clk); #1;
    chk("b_idle2_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("b_mis_valid", 32'(b_rsp_valid), 32'd1);
    chk("b_mis_err", 32'(b_rsp_err), 32'd1);
    chk("b_mis_rdata", b_rsp_rdata, 32'd0);
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_end_valid", 32'(b_rsp_valid), 32'd0);
    chk("b_end_ready", 32'(b_req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
